// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and shared-memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    i_req_i;
  logic [ADDR_WIDTH-1:0]   i_addr_i;
  logic                    i_gnt_o;
  logic                    i_rvalid_o;
  logic [DATA_WIDTH-1:0]   i_rdata_o;
  logic                    d_req_i;
  logic                    d_we_i;
  logic [DATA_WIDTH/8-1:0] d_be_i;
  logic [ADDR_WIDTH-1:0]   d_addr_i;
  logic [DATA_WIDTH-1:0]   d_wdata_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [DATA_WIDTH-1:0]   d_rdata_o;
  logic                    m_req_o;
  logic                    m_we_o;
  logic [DATA_WIDTH/8-1:0] m_be_o;
  logic [ADDR_WIDTH-1:0]   m_addr_o;
  logic [DATA_WIDTH-1:0]   m_wdata_o;
  logic                    m_gnt_i;
  logic                    m_rvalid_i;
  logic [DATA_WIDTH-1:0]   m_rdata_i;
  logic                    busy_o;

  // master: requesters plus memory model; slave: the arbiter itself
  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
    input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o, busy_o
  );
  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
    output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
// Data wins by default; fetch is forced through after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    m_req_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic                    m_gnt_i,
  input  logic                    m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  output logic                    busy_o
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic                  m_we_q, m_we_d;
  logic [BE_W-1:0]       m_be_q, m_be_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  i_wins;
  logic                  hs_gnt;
  logic                  hs_rvalid;

  assign i_wins = i_req_i && (!d_req_i || (starve_q == STARVE_MAX));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_i || d_req_i) begin
          state_d = ST_REQ;
          if (i_wins) begin
            owner_d   = OWN_I;
            starve_d  = 4'd0;
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = i_addr_i;
            m_wdata_d = '0;
          end else begin
            owner_d   = OWN_D;
            m_we_d    = d_we_i;
            m_be_d    = d_be_i;
            m_addr_d  = d_addr_i;
            m_wdata_d = d_wdata_i;
            if (i_req_i && (starve_q < STARVE_MAX)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      // a same-cycle rvalid alongside the grant completes the transaction at once
      ST_REQ: begin
        if (m_gnt_i) begin
          state_d = m_rvalid_i ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      starve_q  <= 4'd0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign hs_gnt    = (state_q == ST_REQ) && m_gnt_i;
  assign hs_rvalid = (hs_gnt && m_rvalid_i) || ((state_q == ST_WAIT) && m_rvalid_i);

  assign i_gnt_o    = hs_gnt && (owner_q == OWN_I);
  assign d_gnt_o    = hs_gnt && (owner_q == OWN_D);
  assign i_rvalid_o = hs_rvalid && (owner_q == OWN_I);
  assign d_rvalid_o = hs_rvalid && (owner_q == OWN_D);
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;

  assign m_req_o   = (state_q == ST_REQ);
  assign m_we_o    = m_we_q;
  assign m_be_o    = m_be_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign busy_o    = (state_q != ST_IDLE);
endmodule
